pulse_pair_driver: RTL

//  Transmit side of the toggle-encoded pulse interface used by the two-input clocked

---
 rtl/pulse_pair_driver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pulse_pair_driver.sv
// Toggle-encoded a -> b -> clk pulse frame generator for clocked pulse gates; one frame per accepted pair.
// Latency: a at accept edge, b at +GAP, clk at +2*GAP, ready again at +3*GAP; no queuing while busy.
module pulse_pair_driver #(
  parameter int GAP         = 4,
  parameter int START_DELAY = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  output logic             a_tgl,
  output logic             b_tgl,
  output logic             clk_tgl,
  output logic             exp_out,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int WW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_PH_A,
    S_PH_B,
    S_PH_C
  } state_t;

  state_t           r_state;
  logic [GW-1:0]    r_cnt;
  logic [WW-1:0]    r_wcnt;
  logic             r_b;
  logic             r_ab;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_a_tgl;
  logic             r_b_tgl;
  logic             r_clk_tgl;
  logic             r_exp;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_b         <= 1'b0;
      r_ab        <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_a_tgl     <= 1'b0;
      r_b_tgl     <= 1'b0;
      r_clk_tgl   <= 1'b0;
      r_exp       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_wcnt == WW'(START_DELAY - 1)) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= S_PH_A;
            r_cnt      <= GW'(GAP - 1);
            r_b        <= in_b;
            r_ab       <= in_a & in_b;
            r_a_tgl    <= r_a_tgl ^ in_a;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        // Skipped pulses still burn their slot so the cadence never depends on data.
        S_PH_A: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_PH_B;
            r_cnt   <= GW'(GAP - 1);
            r_b_tgl <= r_b_tgl ^ r_b;
          end
        end
        S_PH_B: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state   <= S_PH_C;
            r_cnt     <= GW'(GAP - 1);
            r_clk_tgl <= ~r_clk_tgl;
            r_exp     <= r_exp ^ r_ab;
          end
        end
        S_PH_C: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign a_tgl     = r_a_tgl;
  assign b_tgl     = r_b_tgl;
  assign clk_tgl   = r_clk_tgl;
  assign exp_out   = r_exp;
  assign frame_cnt = r_frame_cnt;

endmodule
